uart_cmd_responder: RTL
=======================

# uart_cmd_responder

Byte-level command responder on the host-facing FIFO ports of the `uart` block. It pops command bytes from the receive FIFO and decodes them into register-bus writes and reads. It then pushes a one-byte response into the transmit FIFO. It is the on-chip peer of an external host that drives the serial link.

## Interface
- `DBITS`, 8, data, address and FIFO byte width
- `TIMEOUT_CYC`, 100000, clk cycles allowed between bytes of one command before abort (≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `r_data`  in  DBITS  receive FIFO output; valid the cycle after `rd_uart`
- `rd_uart`  out  1  receive FIFO pop strobe
- `rx_empty`  in  1  receive FIFO empty
- `w_data`  out  DBITS  transmit FIFO input byte
- `wr_uart`  out  1  transmit FIFO push strobe
- `tx_full`  in  1  transmit FIFO full
- `bus_addr`  out  DBITS  register bus address
- `bus_wdata`  out  DBITS  register bus write data
- `bus_we`  out  1  register write strobe, 1 cycle
- `bus_re`  out  1  register read strobe, 1 cycle
- `bus_rdata`  in  DBITS  read data; valid the cycle after `bus_re`
- `busy`  out  1  high in every state except IDLE
- `err_pulse`  out  1  one-cycle pulse on inter-byte timeout

## Operation
- Command set:
  - write: 0x57 ('W'), addr, data. Response is 0x4B ('K').
  - read: 0x52 ('R'), addr. Response is the read byte.
  - Any other first byte is answered with 0x3F ('?'), and no further bytes are consumed.
- States: IDLE, POP_OP, GET_OP, POP_A, GET_A, POP_D, GET_D, EXEC, BUS_WAIT, SEND.
- IDLE: if `rx_empty`=0, assert `rd_uart` and go to GET_OP. POP_OP is the same wait state as IDLE; IDLE doubles as POP_OP with no timeout.
- GET_OP: latch `r_data` as opcode.
  - 'W' or 'R' → POP_A.
  - Other → SEND with 0x3F.
- POP_A / POP_D: wait for `rx_empty`=0, then assert `rd_uart` and go to GET_A / GET_D.
- GET_A: latch `bus_addr`.
  - 'R' → EXEC.
  - 'W' → POP_D.
- GET_D: latch `bus_wdata` → EXEC.
- EXEC:
  - 'W': `bus_we`=1 → SEND with 0x4B.
  - 'R': `bus_re`=1 → BUS_WAIT.
- BUS_WAIT: latch `bus_rdata` into the response register → SEND.
- SEND: if `tx_full`=0, assert `wr_uart` with `w_data`=response → IDLE. Otherwise hold with no push, indefinitely; no timeout in SEND.
- Timeout:
  - The counter clears on every `rd_uart`.
  - It increments each cycle spent in POP_A or POP_D.
  - On reaching `TIMEOUT_CYC`-1 while still waiting: `err_pulse`=1 for that cycle, go to IDLE, send no response.
  - Counter width is clog2(`TIMEOUT_CYC`).
- `rd_uart` is asserted only when `rx_empty`=0. `wr_uart` is asserted only when `tx_full`=0. Both are never high for more than one consecutive cycle.
- `bus_we` and `bus_re` are never high in the same cycle. `bus_addr` and `bus_wdata` hold their last latched values until the next latch.

## Timing
- Reset: state IDLE. `rd_uart`, `wr_uart`, `bus_we`, `bus_re`, `busy`, `err_pulse` = 0. `w_data`, `bus_addr`, `bus_wdata` = 0. Timeout counter = 0.
- Reset mid-command discards the partial command. No bus strobe or FIFO push occurs on the cycle after reset is applied.
- Write, with the data-byte `rd_uart` at cycle t:
  - t+1: GET_D
  - t+2: `bus_we`
  - t+3: `wr_uart` with 0x4B, if not full
  - t+4: IDLE
- Read, with the addr-byte `rd_uart` at cycle t:
  - t+1: GET_A
  - t+2: `bus_re`
  - t+3: `bus_rdata` sampled
  - t+4: `wr_uart`
- Unknown opcode, with the opcode `rd_uart` at cycle t: `wr_uart` with 0x3F at t+2 if not full.
- Back-to-back commands: the next opcode pop occurs no earlier than the cycle after the response push.
- `rx_empty` dropping on the same cycle the timeout expires: the timeout wins, and the byte remains for IDLE.

## Test plan
- Write: push 0x57, 0x05, 0xA3 into RX with `rx_empty` modelled → one `bus_we` with addr 0x05 and wdata 0xA3, then one `wr_uart` with 0x4B.
- Read: push 0x52, 0x05; bench returns `bus_rdata`=0xA3 the cycle after `bus_re` → `wr_uart` with 0xA3, and no `bus_we`.
- Unknown opcode: push 0x41, 0x52, 0x07 → 0x3F response, then a normal read of addr 0x07. This confirms 0x41 did not consume extra bytes.
- Backpressure: hold `tx_full`=1 for 50 cycles during a write response → `wr_uart` stays 0. It pulses exactly once the cycle `tx_full` falls, and `busy` stays 1 throughout.
- Timeout with `TIMEOUT_CYC`=16: push 0x57, 0x02 only → `err_pulse` exactly once, 15 cycles after the addr-byte GET. No `bus_we`, no response; then a following read command works.
- Reset mid-command: assert `reset` one cycle in GET_D → no `bus_we` or `wr_uart`. All outputs are 0 the next cycle and `busy`=0.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// Command responder behind the uart FIFOs: pops W/R command bytes,
// drives a byte-wide register bus and pushes a one-byte reply.
module uart_cmd_responder #(
    parameter int DBITS       = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] r_data,
    output logic             rd_uart,
    input  logic             rx_empty,
    output logic [DBITS-1:0] w_data,
    output logic             wr_uart,
    input  logic             tx_full,
    output logic [DBITS-1:0] bus_addr,
    output logic [DBITS-1:0] bus_wdata,
    output logic             bus_we,
    output logic             bus_re,
    input  logic [DBITS-1:0] bus_rdata,
    output logic             busy,
    output logic             err_pulse
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    localparam logic [DBITS-1:0] OP_W  = DBITS'(8'h57);
    localparam logic [DBITS-1:0] OP_R  = DBITS'(8'h52);
    localparam logic [DBITS-1:0] RSP_K = DBITS'(8'h4B);
    localparam logic [DBITS-1:0] RSP_Q = DBITS'(8'h3F);

    typedef enum logic [3:0] {
        IDLE, POP_OP, GET_OP, POP_A, GET_A,
        POP_D, GET_D, EXEC, BUS_WAIT, SEND
    } state_t;

    state_t           state_q, state_d;
    logic [DBITS-1:0] op_q, op_d;
    logic [DBITS-1:0] addr_q, addr_d;
    logic [DBITS-1:0] wdata_q, wdata_d;
    logic [DBITS-1:0] resp_q, resp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             waiting;
    logic             expire;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_d    = resp_q;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        err_pulse = 1'b0;
        waiting   = (state_q == POP_A) || (state_q == POP_D);
        // counter lands on TIMEOUT_CYC-1 this cycle; beats a newly arrived byte
        expire    = waiting && (cnt_q == CW'(TIMEOUT_CYC - 2));
        case (state_q)
            IDLE, POP_OP: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                op_d = r_data;
                if (r_data == OP_W || r_data == OP_R) begin
                    state_d = POP_A;
                end else begin
                    resp_d  = RSP_Q;
                    state_d = SEND;
                end
            end
            POP_A, POP_D: begin
                if (expire) begin
                    err_pulse = 1'b1;
                    state_d   = IDLE;
                end else if (!rx_empty) begin
                    rd_uart = 1'b1;
                    state_d = (state_q == POP_A) ? GET_A : GET_D;
                end
            end
            GET_A: begin
                addr_d  = r_data;
                state_d = (op_q == OP_R) ? EXEC : POP_D;
            end
            GET_D: begin
                wdata_d = r_data;
                state_d = EXEC;
            end
            EXEC: begin
                if (op_q == OP_W) begin
                    bus_we  = 1'b1;
                    resp_d  = RSP_K;
                    state_d = SEND;
                end else begin
                    bus_re  = 1'b1;
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                resp_d  = bus_rdata;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            rd_uart   = 1'b0;
            wr_uart   = 1'b0;
            bus_we    = 1'b0;
            bus_re    = 1'b0;
            err_pulse = 1'b0;
        end
        cnt_d = cnt_q;
        if (rd_uart) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    assign w_data    = resp_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
